// File: rtl/arb16_hold_ctrl_pkg.sv
// arb16_hold_ctrl_pkg: shared types, sizes and the 4-to-2 priority helper for the arbiter
package arb16_hold_ctrl_pkg;
    localparam int NREQ = 16;
    localparam int CODE_W = 4;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    function automatic logic [1:0] enc4(input logic [3:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/arb16_hold_ctrl_prio_enc16_tree.sv
// prio_enc16_tree: 16-to-4 highest-index priority encoder built from 4-to-2 leaves
module prio_enc16_tree
    import arb16_hold_ctrl_pkg::*;
(
    input  logic [NREQ-1:0]   vec_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o
);
    logic [3:0] grp_v;
    logic [1:0] leaf_c [4];
    logic [1:0] hi;
    for (genvar i = 0; i < 4; i++) begin : g_leaf
        assign grp_v[i]  = |vec_i[4*i +: 4];
        assign leaf_c[i] = enc4(vec_i[4*i +: 4]);
    end
    assign hi      = enc4(grp_v);
    assign code_o  = {hi, leaf_c[hi]};
    assign valid_o = |grp_v;
endmodule

// File: rtl/arb16_hold_ctrl.sv
// arb16_hold_ctrl: 16-way fixed/round-robin arbiter with registered grant, hold timeout and a one-cycle gap
module arb16_hold_ctrl
    import arb16_hold_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic              rr_mode,
    output logic [NREQ-1:0]   gnt,
    output logic [CODE_W-1:0] gnt_code,
    output logic              gnt_valid,
    output logic              timeout
);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d, masked;
    logic [CODE_W-1:0]   code_q, code_d, last_q, last_d, r_code, m_code, win;
    logic [CW-1:0]       hold_q, hold_d;
    logic                valid_q, valid_d, timeout_q, timeout_d, r_valid, m_valid, expire;
    // Only requesters below the previous winner compete first, so priority rotates downward.
    assign masked = req & ((NREQ'(1) << last_q) - NREQ'(1));
    prio_enc16_tree u_enc_req (.vec_i(req),    .code_o(r_code), .valid_o(r_valid));
    prio_enc16_tree u_enc_msk (.vec_i(masked), .code_o(m_code), .valid_o(m_valid));
    assign win    = (rr_mode && m_valid) ? m_code : r_code;
    assign expire = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && |(req & ~gnt_q);
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        code_d    = code_q;
        valid_d   = valid_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == GRANT) begin
            if (!req[code_q] || expire) begin
                state_d   = GAP;
                gnt_d     = '0;
                valid_d   = 1'b0;
                last_d    = code_q;
                timeout_d = req[code_q];
            end else if (hold_q < HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end
        end else if (r_valid) begin
            state_d = GRANT;
            gnt_d   = NREQ'(1) << win;
            code_d  = win;
            valid_d = 1'b1;
            hold_d  = CW'(1);
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end
    assign gnt       = gnt_q;
    assign gnt_code  = code_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_arb16_hold_ctrl.sv
// tb_arb16_hold_ctrl: directed scenarios plus randomized traffic against a behavioural arbiter model
module tb_arb16_hold_ctrl;
    localparam int MH = 4;
    logic        clk = 1'b0, reset = 1'b1, rr_mode = 1'b0, gnt_valid, timeout;
    logic [15:0] req = '0, gnt;
    logic [3:0]  gnt_code;
    int checks = 0, passed = 0;
    int m_st = 0, m_last = 0, m_hold = 0, m_code = 0;
    bit m_valid = 0, m_to = 0;

    arb16_hold_ctrl #(.MAX_HOLD(MH), .CW(5)) dut (
        .clk(clk), .reset(reset), .req(req), .rr_mode(rr_mode),
        .gnt(gnt), .gnt_code(gnt_code), .gnt_valid(gnt_valid), .timeout(timeout));

    always #5 clk = ~clk;

    function automatic int arb(input logic [15:0] r, input bit rr, input int last);
        if (rr) begin
            for (int k = 1; k <= 16; k++) if (r[(last - k + 16) % 16]) return (last - k + 16) % 16;
        end else begin
            for (int i = 15; i >= 0; i--) if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [15:0] m_gnt();
        return m_valid ? (16'h1 << m_code) : 16'h0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_last = 0; m_hold = 0; m_code = 0; m_valid = 0; m_to = 0;
    endtask

    task automatic step();
        int st = m_st, last = m_last, hold = m_hold, code = m_code;
        bit valid = m_valid, to = 0;
        if (m_st != 1) begin
            if (req != 0) begin st = 1; code = arb(req, rr_mode, m_last); valid = 1; hold = 1; end
            else begin st = 0; valid = 0; end
        end else if (!req[m_code]) begin
            st = 2; valid = 0; last = m_code;
        end else if (MH != 0 && m_hold == MH && (req & ~(16'h1 << m_code)) != 0) begin
            st = 2; valid = 0; to = 1; last = m_code;
        end else if (m_hold < MH) begin
            hold = m_hold + 1;
        end
        @(posedge clk); #1;
        m_st = st; m_last = last; m_hold = hold; m_code = code; m_valid = valid; m_to = to;
    endtask

    task automatic do_reset();
        req = '0; reset = 1'b1; model_reset(); #3; reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) begin
            step();
            checks++; if ({gnt, gnt_code, gnt_valid, timeout} !== 22'h0) $display("FAIL reset_idle got=%h/%h/%b/%b exp=0", gnt, gnt_code, gnt_valid, timeout); else passed++;
        end
        req = 16'h0100; step();
        checks++; if (gnt !== 16'h0100) $display("FAIL reset_pregrant got=%h exp=%h", gnt, 16'h0100); else passed++;
        #2 reset = 1'b1; #1;
        checks++; if ({gnt, gnt_valid} !== 17'h0) $display("FAIL reset_async got=%h/%b exp=0/0", gnt, gnt_valid); else passed++;
        model_reset(); req = '0; #2 reset = 1'b0;
    endtask

    task automatic test_fixed();
        rr_mode = 1'b0; req = 16'h0A10; step();
        checks++; if (gnt !== 16'h0800 || gnt_code !== 4'd11) $display("FAIL fixed_first got=%h/%0d exp=0800/11", gnt, gnt_code); else passed++;
        step(); step();
        req = 16'h0210; step();
        checks++; if (gnt !== 16'h0 || gnt_valid !== 1'b0) $display("FAIL fixed_gap got=%h/%b exp=0000/0", gnt, gnt_valid); else passed++;
        checks++; if (gnt_code !== 4'd11) $display("FAIL fixed_code_hold got=%0d exp=11", gnt_code); else passed++;
        step();
        checks++; if (gnt !== 16'h0200 || gnt_code !== 4'd9) $display("FAIL fixed_second got=%h/%0d exp=0200/9", gnt, gnt_code); else passed++;
        req = '0; step(); step();
    endtask

    task automatic test_rr();
        int exp;
        do_reset(); rr_mode = 1'b1; req = 16'hFFFF; step();
        for (int n = 0; n <= 16; n++) begin
            exp = (15 - n) & 15;
            checks++; if (gnt_code !== 4'(exp) || gnt !== (16'h1 << exp)) $display("FAIL rr_seq[%0d] got=%0d/%h exp=%0d", n, gnt_code, gnt, exp); else passed++;
            req[exp] = 1'b0; step(); req = 16'hFFFF;
            checks++; if (gnt !== 16'h0) $display("FAIL rr_gap[%0d] got=%h exp=0000", n, gnt); else passed++;
            step();
        end
        req = '0; step(); step();
    endtask

    task automatic test_timeout();
        do_reset(); rr_mode = 1'b0; req = 16'h8001; step();
        repeat (MH) begin
            checks++; if (gnt !== 16'h8000 || timeout !== 1'b0) $display("FAIL to_hold got=%h/%b exp=8000/0", gnt, timeout); else passed++;
            step();
        end
        checks++; if (gnt !== 16'h0 || timeout !== 1'b1) $display("FAIL to_gap got=%h/%b exp=0000/1", gnt, timeout); else passed++;
        step();
        checks++; if (gnt !== 16'h8000 || timeout !== 1'b0) $display("FAIL to_regrant got=%h/%b exp=8000/0", gnt, timeout); else passed++;
        rr_mode = 1'b1;
        repeat (MH) step();
        checks++; if (gnt !== 16'h0 || timeout !== 1'b1) $display("FAIL to_gap_rr got=%h/%b exp=0000/1", gnt, timeout); else passed++;
        step();
        checks++; if (gnt !== 16'h0001 || timeout !== 1'b0) $display("FAIL to_rr_next got=%h/%b exp=0001/0", gnt, timeout); else passed++;
        req = '0; step(); step();
    endtask

    task automatic test_sole();
        do_reset(); rr_mode = 1'b0; req = 16'h0004;
        repeat (40) begin
            step();
            checks++; if (gnt !== 16'h0004 || timeout !== 1'b0) $display("FAIL sole got=%h/%b exp=0004/0", gnt, timeout); else passed++;
        end
        req = '0; step(); step();
    endtask

    task automatic test_rr_switch();
        do_reset(); rr_mode = 1'b0; req = 16'h003F; step();
        checks++; if (gnt_code !== 4'd5) $display("FAIL sw_first got=%0d exp=5", gnt_code); else passed++;
        req = 16'h0FFF; rr_mode = 1'b1; step(); step();
        checks++; if (gnt !== 16'h0020) $display("FAIL sw_held got=%h exp=0020", gnt); else passed++;
        req = 16'h0FDF; step(); step();
        checks++; if (gnt_code !== 4'd4 || gnt !== 16'h0010) $display("FAIL sw_next got=%0d/%h exp=4/0010", gnt_code, gnt); else passed++;
        req = '0; step(); step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 25 == 0) rr_mode = 1'($urandom);
            req = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
            step();
            checks++; if ({gnt, gnt_code, gnt_valid, timeout} !== {m_gnt(), 4'(m_code), m_valid, m_to})
                $display("FAIL rand[%0d] got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", c, gnt, gnt_code, gnt_valid, timeout, m_gnt(), m_code, m_valid, m_to);
            else passed++;
            checks++; if (gnt_valid !== |gnt || (gnt & (gnt - 16'h1)) !== 16'h0) $display("FAIL rand_inv[%0d] got=%h/%b exp=onehot", c, gnt, gnt_valid); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_timeout();
        test_sole();
        test_rr_switch();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/arb16_hold_ctrl.md
Name: arb16_hold_ctrl

Overview:
- 16-requester arbiter that shares one downstream resource between requesters.
- Each arbitration decision is built on a 16-to-4 priority encode of the request vector.
- Two selectable policies: fixed priority (highest index wins) or round-robin.
- The winner holds a registered grant until it drops its request or a hold timeout expires.
- The block sits in front of the shared resource and drives its select code.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles while other requests are pending; 0 disables the timeout.
- CW, 5: hold counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  16  request vector; bit i is requester i; a requester keeps its bit high until served.
- rr_mode  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE/GAP.
- gnt  out  16  registered one-hot grant, or all zero.
- gnt_code  out  4  binary index of the current grant; holds the last winner when gnt_valid = 0.
- gnt_valid  out  1  high whenever gnt is non-zero.
- timeout  out  1  one-cycle pulse on the cycle a grant is forcibly revoked.

Behaviour:
- Reset, asynchronous: state = IDLE; gnt = 0; gnt_code = 0; gnt_valid = 0; timeout = 0; last = 0; hold_cnt = 0.
- All outputs are registered. No combinational path from req to any output.
- Arbitration function (combinational, used only in IDLE/GAP):
  - Fixed mode: winner = highest set index of req.
  - RR mode: masked = req & ((1 << last) - 1).
    - If masked != 0, winner = highest set index of masked.
    - Otherwise winner = highest set index of req (wrap).
    - Result: priority rotates downward from last - 1, wrapping to 15.
  - Consequence: after reset (last = 0), the first RR grant equals the fixed-mode winner.
- FSM states: IDLE, GRANT, GAP.
  - IDLE: if req != 0, the next edge moves to GRANT with gnt = onehot(winner), gnt_code = winner, gnt_valid = 1, hold_cnt = 1. This gives 1-cycle latency from req to gnt. If req == 0, stay in IDLE.
  - GRANT: let g = gnt_code.
    - If req[g] = 0, the next edge goes to GAP: gnt = 0, gnt_valid = 0, last = g.
    - Else if MAX_HOLD != 0, hold_cnt == MAX_HOLD, and (req with bit g cleared) != 0, the next edge goes to GAP with timeout = 1 for that one cycle and last = g.
    - Otherwise stay in GRANT; hold_cnt increments and saturates at MAX_HOLD.
  - GAP: exactly one dead cycle with gnt = 0, guaranteeing break-before-make on the shared resource. Arbitrates exactly as IDLE does: next edge goes to GRANT if req != 0, else to IDLE.
- Boundary conditions:
  - A sole requester is never timed out; its grant is held indefinitely.
  - A requester whose grant was revoked by timeout and still requests re-competes normally. In RR mode it ranks last; in fixed mode it may immediately win again.
  - A request that deasserts in the same cycle the grant is issued: the grant still lasts ≥1 cycle, then the FSM goes to GAP.
  - A rr_mode change during GRANT has no effect until the next arbitration.
  - The last register updates only on leaving GRANT.
  - Reset mid-grant: gnt drops to 0 asynchronously.
- Invariants:
  - At most one gnt bit is set.
  - gnt_valid == |gnt.
  - gnt[gnt_code] == gnt_valid.

Decomposition:
- Shared package: state enum (IDLE, GRANT, GAP), constant NREQ = 16, constant CODE_W = 4.
- One sub-module: prio_enc16_tree. It is a combinational 16-to-4 priority encoder with an any-valid output, built as four 4-to-2 leaf encoders plus a second-level 4-to-2 encoder and a code mux.
- The arbiter instantiates prio_enc16_tree twice, once on req and once on masked; the masked encoder's any-valid output selects between them.
- The FSM, mask, counter, and output registers live in the top module.

Test Plan:
1. Reset release, req = 16'h0000 for 5 cycles → gnt = 0, gnt_valid = 0, gnt_code = 0, state IDLE. Assert reset while gnt = 16'h0100 → gnt = 0 immediately, without waiting for a clock edge.
2. Fixed mode, req = 16'h0A10 at cycle 0 → cycle 1: gnt = 16'h0800, gnt_code = 11. Drop req[11] at cycle 3 → cycle 4: gnt = 0 (GAP). Cycle 5: gnt = 16'h0200, gnt_code = 9.
3. RR mode, req = 16'hFFFF held; each grant is released by pulsing its req bit low for one cycle → grant sequence 15, 14, 13 … 0, 15, with exactly one gap cycle between grants.
4. Timeout, MAX_HOLD = 4, fixed mode, req = 16'h8001 held → gnt = 16'h8000 for exactly 4 cycles; timeout pulses in the GAP cycle, gnt = 0 that cycle; then gnt = 16'h8000 again. With rr_mode = 1 the next grant after the GAP is instead 16'h0001.
5. Sole requester, req = 16'h0004 held for 40 cycles, MAX_HOLD = 4 → gnt = 16'h0004 continuously, timeout never asserts.
6. rr_mode toggled 0→1 during a grant to index 5, with req = 16'h0FFF → current grant is unaffected. After release, the next grant is index 4, not 11.
